// File: rtl/grant_decoder_pkg.sv
// Shared types and defaults for the grant decoder and its hold timer.
package grant_pkg;

  localparam int DEFAULT_N       = 8;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/grant_decoder_hold_timer.sv
// Saturating hold counter: cleared while no grant is held, counts grant cycles,
// flags the last permitted cycle (count == TIMEOUT-1).
module hold_timer
  import grant_pkg::*;
#(
  parameter int  TIMEOUT = DEFAULT_TIMEOUT,
  localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/grant_decoder.sv
// Turns an accepted requester index into a registered one-hot grant, held until
// the grantee's done bit or a timeout, followed by a one-cycle release gap.
module grant_decoder
  import grant_pkg::*;
#(
  parameter int  N       = DEFAULT_N,
  parameter int  TIMEOUT = DEFAULT_TIMEOUT,
  localparam int W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_enc_valid,
  input  logic [W-1:0] i_enc,
  output logic         o_enc_ready,
  input  logic [N-1:0] i_done,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_grant_id,
  output logic         o_busy,
  output logic         o_timeout,
  output logic         o_err
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_grant;
  logic [N-1:0] w_grant_nxt;
  logic [W-1:0] r_grant_id;
  logic [W-1:0] w_grant_id_nxt;
  logic         r_busy;
  logic         w_busy_nxt;
  logic         r_timeout;
  logic         w_timeout_nxt;
  logic         r_err;
  logic         w_err_nxt;

  logic         w_accept;
  logic         w_in_range;
  logic         w_done_hit;
  logic         w_expired;
  logic [N-1:0] w_onehot;

  assign w_accept   = (r_state == IDLE) && i_enc_valid;
  // Only reachable as false when N is not a power of two.
  assign w_in_range = (int'(i_enc) < N);
  assign w_onehot   = {{(N-1){1'b0}}, 1'b1} << i_enc;
  assign w_done_hit = i_done[r_grant_id];

  hold_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_hold_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (r_state != GRANT),
    .i_en      (r_state == GRANT),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_busy_nxt     = r_busy;
    w_timeout_nxt  = 1'b0;
    w_err_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_in_range) begin
            w_state_nxt    = GRANT;
            w_grant_nxt    = w_onehot;
            w_grant_id_nxt = i_enc;
            w_busy_nxt     = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      GRANT: begin
        // Release by done takes precedence over the timeout on the same cycle.
        if (w_done_hit || w_expired) begin
          w_state_nxt    = RELEASE;
          w_grant_nxt    = '0;
          w_grant_id_nxt = '0;
          w_busy_nxt     = 1'b0;
          w_timeout_nxt  = !w_done_hit;
        end
      end
      RELEASE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt    = IDLE;
        w_grant_nxt    = '0;
        w_grant_id_nxt = '0;
        w_busy_nxt     = 1'b0;
      end
    endcase
  end

  assign o_enc_ready = (r_state == IDLE);
  assign o_grant     = r_grant;
  assign o_grant_id  = r_grant_id;
  assign o_busy      = r_busy;
  assign o_timeout   = r_timeout;
  assign o_err       = r_err;

endmodule
